reg_writeback: RTL and testbench

Writeback stage for the single-cycle datapath: the writer side of the register-file write port (RegWrite, a3, wd3) that the instruction-decode register file consumes. It accepts completed instructions from execute/memory over a valid/ready handshake and selects the result source (ALU, load data, PC+4, or immediate). Results are buffered in a small in-order queue and retired one per cycle onto the write port. It also reports pending-write hazards for the decode read addresses.

---
 rtl/reg_writeback.sv | 100 ++++++++++
 tb/tb_reg_writeback.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback stage: in-order result queue retiring one register write per cycle, with decode hazard lookup.
// Latency 1 cycle accept-to-write; in_ready drops when full or flushing, wb_stall holds the head entry.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_regwrite,
  input  logic [4:0]               in_rd,
  input  logic [1:0]               in_wb_sel,
  input  logic [31:0]              in_alu,
  input  logic [31:0]              in_mem,
  input  logic [31:0]              in_pc4,
  input  logic [31:0]              in_imm,
  input  logic                     flush,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [4:0]               a3,
  output logic [31:0]              wd3,
  input  logic [4:0]               hz_a1,
  input  logic [4:0]               hz_a2,
  output logic                     hz1,
  output logic                     hz2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]    rdMem   [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr, offset;
  logic [PW:0]   cnt;
  logic          full, empty, accept, push, pop;
  logic [31:0]   selData;

  always_comb begin
    case (in_wb_sel)
      2'b00:   selData = in_alu;
      2'b01:   selData = in_mem;
      2'b10:   selData = in_pc4;
      default: selData = in_imm;
    endcase
  end

  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  // x0 and non-writing instructions complete the handshake but occupy no slot
  assign push     = accept && in_regwrite && (in_rd != 5'd0);
  assign pop      = !empty && !wb_stall && !flush;

  assign RegWrite = pop;
  assign a3       = empty ? 5'd0  : rdMem[rdPtr];
  assign wd3      = empty ? 32'd0 : dataMem[rdPtr];
  assign count    = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[wrPtr]   <= in_rd;
      dataMem[wrPtr] <= selData;
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    hz1    = 1'b0;
    hz2    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rdPtr;
      if ({1'b0, offset} < cnt) begin
        if (hz_a1 != 5'd0 && rdMem[i] == hz_a1) hz1 = 1'b1;
        if (hz_a2 != 5'd0 && rdMem[i] == hz_a2) hz2 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback, checked against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu, in_mem, in_pc4, in_imm;
  logic        flush, wb_stall;
  logic        RegWrite;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  hz_a1, hz_a2;
  logic        hz1, hz2;
  logic [2:0]  count;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } entry_t;
  entry_t model[$];

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4), .in_imm(in_imm),
    .flush(flush), .wb_stall(wb_stall),
    .RegWrite(RegWrite), .a3(a3), .wd3(wd3),
    .hz_a1(hz_a1), .hz_a2(hz_a2), .hz1(hz1), .hz2(hz2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks all outputs against the model, then advances the model at the edge.
  task automatic step(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [31:0] imm, input logic fl, input logic st,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic   expReady, expWrite, expH1, expH2;
    logic [31:0] value;
    entry_t e;
    in_valid = v; in_regwrite = rw; in_rd = rd; in_wb_sel = sel;
    in_alu = alu; in_mem = mem; in_pc4 = pc4; in_imm = imm;
    flush = fl; wb_stall = st; hz_a1 = a1; hz_a2 = a2;
    #2;
    expReady = (model.size() < DEPTH) && !fl;
    expWrite = (model.size() > 0) && !st && !fl;
    expH1 = 1'b0;
    expH2 = 1'b0;
    foreach (model[k]) begin
      if (a1 != 0 && model[k].rd == a1) expH1 = 1'b1;
      if (a2 != 0 && model[k].rd == a2) expH2 = 1'b1;
    end
    chk("in_ready", in_ready, expReady);
    chk("RegWrite", RegWrite, expWrite);
    chk("a3",  a3,  model.size() > 0 ? model[0].rd : 5'd0);
    chk("wd3", wd3, model.size() > 0 ? model[0].d  : 32'd0);
    chk("hz1", hz1, expH1);
    chk("hz2", hz2, expH2);
    chk("count", count, model.size());
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (expWrite) void'(model.pop_front());
      if (v && expReady && rw && rd != 0) begin
        value = (sel == 2'd0) ? alu : (sel == 2'd1) ? mem : (sel == 2'd2) ? pc4 : imm;
        e.rd = rd;
        e.d  = value;
        model.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 5'd0, 2'd0, 0, 0, 0, 0, 1'b0, st, 5'd0, 5'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd4; in_wb_sel = 2'd0;
    in_alu = 32'h55; in_mem = 0; in_pc4 = 0; in_imm = 0;
    flush = 1'b0; wb_stall = 1'b0; hz_a1 = 5'd4; hz_a2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst RegWrite", RegWrite, 0);
    chk("rst a3", a3, 0);
    chk("rst wd3", wd3, 0);
    chk("rst count", count, 0);
    chk("rst hz1", hz1, 0);
    reset_n = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Source select on four consecutive accepts
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 5'(5 + i), 2'(i), 32'h11, 32'h22, 32'h104, 32'hABCDE000, 1'b0, 1'b0, 5'd7, 5'd8);
    repeat (4) idle(1'b0);

    // x0 and non-writing instructions are discarded
    step(1'b1, 1'b1, 5'd0, 2'd0, 32'h1, 0, 0, 0, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd9, 2'd0, 32'h2, 0, 0, 0, 1'b0, 1'b0, 5'd9, 5'd0);
    idle(1'b0);

    // Fill under stall, then release with the fifth offer still pending
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b1, 5'(i), 2'd0, 32'(i * 16), 0, 0, 0, 1'b0, 1'b1, 5'd3, 5'd0);
    repeat (6) step(1'b1, 1'b1, 5'd5, 2'd0, 32'h50, 0, 0, 0, 1'b0, 1'b0, 5'd3, 5'd5);
    repeat (2) idle(1'b0);

    // Flush with two queued entries and an offer
    step(1'b1, 1'b1, 5'd11, 2'd0, 32'hB, 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd12, 2'd0, 32'hC, 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd10, 2'd0, 32'hA, 0, 0, 0, 1'b1, 1'b0, 5'd10, 5'd11);
    idle(1'b0);

    // Push and pop together at count 2
    step(1'b1, 1'b1, 5'd13, 2'd0, 32'hD, 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd14, 2'd0, 32'hE, 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    repeat (3) step(1'b1, 1'b1, 5'd15, 2'd1, 0, 32'hF0, 0, 0, 1'b0, 1'b0, 5'd15, 5'd13);
    repeat (4) idle(1'b0);

    // Randomized traffic with small register range to provoke hazards and duplicates
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
           2'($urandom), $urandom, $urandom, $urandom, $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    // Mid-stream asynchronous reset discards queued entries immediately
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'(20 + i), 2'd0, 32'(i), 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    in_valid = 1'b0; hz_a1 = 5'd20;
    reset_n = 1'b0;
    #1;
    chk("arst RegWrite", RegWrite, 0);
    chk("arst count", count, 0);
    chk("arst a3", a3, 0);
    chk("arst hz1", hz1, 0);
    model.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
